// File: rtl/toast_if_stage_pkg.sv
// Shared constants and state encoding for the TOAST instruction-fetch stage.
package toast_if_stage_pkg;

    localparam int unsigned  XLEN_DEF      = 32;
    localparam logic [31:0]  RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0]  NOP_INSTR_DEF = 32'h0000_0013;   // addi x0,x0,0

    // Fetch sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,   // one cycle after reset, no request
        S_FETCH = 3'd1,   // request on the bus, waiting for gnt
        S_WAIT  = 3'd2,   // granted, waiting for rvalid
        S_HOLD  = 3'd3,   // response parked while ID stalls
        S_DRAIN = 3'd4    // redirected, next rvalid is stale
    } if_state_e;

endpackage

// File: rtl/toast_if_stage_pc_gen.sv
// Fetch PC register: +4 on each granted request, redirect to a word-aligned target.
module toast_if_stage_pc_gen
    import toast_if_stage_pkg::*;
#(
    parameter int unsigned           W        = XLEN_DEF,
    parameter logic [W-1:0]          RESET_PC = W'(RESET_PC_DEF)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_advance,
    input  logic         i_redirect,
    input  logic [W-1:0] i_dest,
    output logic [W-1:0] o_pc
);

    logic [W-1:0] r_pc;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_dest_aligned;

    // Wraps naturally modulo 2^W
    assign w_pc_inc       = r_pc + W'(4);
    assign w_dest_aligned = i_dest & ~W'(3);

    // Redirect beats the increment when both land in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pc <= RESET_PC;
        else if (i_redirect)
            r_pc <= w_dest_aligned;
        else if (i_advance)
            r_pc <= w_pc_inc;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/toast_if_stage.sv
// TOAST IF stage: single-outstanding instruction fetch with stall hold buffer,
// branch redirect with stale-response drain, and bubble insertion on flush.
module toast_if_stage
    import toast_if_stage_pkg::*;
#(
    parameter int unsigned                REG_DATA_WIDTH = XLEN_DEF,
    parameter logic [REG_DATA_WIDTH-1:0]  RESET_PC       = REG_DATA_WIDTH'(RESET_PC_DEF),
    parameter logic [REG_DATA_WIDTH-1:0]  NOP_INSTR      = REG_DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      branch_en_i,
    input  logic [REG_DATA_WIDTH-1:0] branch_dest_i,
    output logic                      imem_req_o,
    output logic [REG_DATA_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [REG_DATA_WIDTH-1:0] imem_rdata_i,
    output logic [REG_DATA_WIDTH-1:0] IF_pc_o,
    output logic [REG_DATA_WIDTH-1:0] IF_instruction_o,
    output logic                      IF_valid_o
);

    localparam int unsigned W = REG_DATA_WIDTH;

    if_state_e    r_state;
    logic [W-1:0] r_req_pc;       // address of the request in flight
    logic [W-1:0] r_hold_pc;
    logic [W-1:0] r_hold_instr;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_instr;
    logic         r_vld;

    logic [W-1:0] w_fetch_pc;
    logic         w_gnt_fire;
    logic         w_rsp_live;
    logic         w_in_flight;

    assign w_gnt_fire = (r_state == S_FETCH) && imem_gnt_i;
    // Only a response in WAIT belongs to the current stream; IDLE/FETCH/DRAIN ignore rvalid
    assign w_rsp_live = (r_state == S_WAIT) && imem_rvalid_i;
    // A response is still owed after this edge: drain it if we redirect now
    assign w_in_flight = w_gnt_fire ||
                         (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid_i);

    toast_if_stage_pc_gen #(
        .W        (W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_advance  (w_gnt_fire),
        .i_redirect (branch_en_i),
        .i_dest     (branch_dest_i),
        .o_pc       (w_fetch_pc)
    );

    assign imem_req_o  = (r_state == S_FETCH);
    assign imem_addr_o = w_fetch_pc;

    // Fetch sequencer, hold buffer and IF output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_req_pc     <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_pc         <= '0;
            r_instr      <= NOP_INSTR;
            r_vld        <= 1'b0;
        end else if (branch_en_i) begin
            // Redirect: squash everything on the old path, keep the pc field
            r_state      <= w_in_flight ? S_DRAIN : S_FETCH;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_instr      <= NOP_INSTR;
            r_vld        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_gnt_i) begin
                        r_req_pc <= w_fetch_pc;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (stall_i) begin
                            r_hold_pc    <= r_req_pc;
                            r_hold_instr <= imem_rdata_i;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HOLD:  if (!stall_i) r_state <= S_FETCH;
                S_DRAIN: if (imem_rvalid_i) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase

            // Flush only touches the output register; the fetch side carries on
            if (flush_i) begin
                r_instr <= NOP_INSTR;
                r_vld   <= 1'b0;
            end else if (!stall_i) begin
                if (w_rsp_live) begin
                    r_pc    <= r_req_pc;
                    r_instr <= imem_rdata_i;
                    r_vld   <= 1'b1;
                end else if (r_state == S_HOLD) begin
                    r_pc    <= r_hold_pc;
                    r_instr <= r_hold_instr;
                    r_vld   <= 1'b1;
                end else begin
                    r_instr <= NOP_INSTR;
                    r_vld   <= 1'b0;
                end
            end
        end
    end

    assign IF_pc_o          = r_pc;
    assign IF_instruction_o = r_instr;
    assign IF_valid_o       = r_vld;

endmodule
